// File: rtl/cve2_fpu_result_sink_if.sv
// Handshake bundle between the FPU output port, the result sink and register-file writeback.
// The sink uses the slave modport; the FPU/writeback side uses master.
interface cve2_fpu_result_sink_if #(
    parameter int TagWidth = 5
);
    logic [31:0]         fpu_result;
    logic [4:0]          fpu_status;
    logic [TagWidth-1:0] fpu_tag;
    logic                fpu_out_valid;
    logic                fpu_out_ready;
    logic                wb_valid;
    logic                wb_ready;
    logic [31:0]         wb_wdata;
    logic [TagWidth-1:0] wb_rd;

    modport master (
        output fpu_result, fpu_status, fpu_tag, fpu_out_valid, wb_ready,
        input  fpu_out_ready, wb_valid, wb_wdata, wb_rd
    );

    modport slave (
        input  fpu_result, fpu_status, fpu_tag, fpu_out_valid, wb_ready,
        output fpu_out_ready, wb_valid, wb_wdata, wb_rd
    );
endinterface

// File: rtl/cve2_fpu_result_sink.sv
// In-order FPU result FIFO feeding writeback, with sticky fflags accumulated from retired entries only.
// Optional same-cycle empty-FIFO bypass is enabled by defining CVE2_FPU_SINK_BYPASS_EN.
module cve2_fpu_result_sink #(
    parameter int  Depth    = 2,
    parameter int  TagWidth = 5,
    localparam int PtrW     = $clog2(Depth),
    localparam int CntW     = $clog2(Depth + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    cve2_fpu_result_sink_if.slave   bus,
    input  logic                    flush_i,
    output logic [4:0]              fflags_o,
    input  logic                    fflags_we_i,
    input  logic [4:0]              fflags_wdata_i,
    output logic [CntW-1:0]         count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [31:0]         data_q   [Depth];
    logic [TagWidth-1:0] tag_q    [Depth];
    logic [4:0]          status_q [Depth];

    logic [PtrW-1:0] wrPtr_q, wrPtr_d;
    logic [PtrW-1:0] rdPtr_q, rdPtr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [4:0]      fflags_q, fflags_d;

    logic full, empty, push, pop, store, bypass;
    logic [4:0] retireStatus;

    assign full  = (count_q == DepthCnt);
    assign empty = (count_q == '0);

    // Ready depends only on registered occupancy, so wb_ready never reaches the FPU combinationally.
    assign bus.fpu_out_ready = ~full;
    assign push = bus.fpu_out_valid & ~full & ~flush_i;
    assign pop  = ~empty & bus.wb_ready & ~flush_i;

`ifdef CVE2_FPU_SINK_BYPASS_EN
    assign bypass = empty & push & bus.wb_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed result retires immediately and is never written into the buffer.
    assign store = push & ~bypass;

    always_comb begin
        bus.wb_valid = 1'b0;
        bus.wb_wdata = '0;
        bus.wb_rd    = '0;
        retireStatus = '0;
        if (bypass) begin
            bus.wb_valid = 1'b1;
            bus.wb_wdata = bus.fpu_result;
            bus.wb_rd    = bus.fpu_tag;
            retireStatus = bus.fpu_status;
        end else if (!empty) begin
            bus.wb_valid = 1'b1;
            bus.wb_wdata = data_q[rdPtr_q];
            bus.wb_rd    = tag_q[rdPtr_q];
            if (pop) begin
                retireStatus = status_q[rdPtr_q];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (flush_i) begin
            count_d = '0;
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (store) begin
                wrPtr_d = wrPtr_q + PtrW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PtrW'(1);
            end
            case ({store, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // A CSR write replaces the flags but the flags of the result retiring this cycle still stick.
    always_comb begin
        fflags_d = fflags_q;
        if (fflags_we_i) begin
            fflags_d = fflags_wdata_i;
        end
        fflags_d = fflags_d | retireStatus;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            fflags_q <= '0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) begin
            data_q[wrPtr_q]   <= bus.fpu_result;
            tag_q[wrPtr_q]    <= bus.fpu_tag;
            status_q[wrPtr_q] <= bus.fpu_status;
        end
    end

    assign fflags_o = fflags_q;
    assign count_o  = count_q;
    assign full_o   = full;
    assign empty_o  = empty;

endmodule

// File: tb/tb_cve2_fpu_result_sink.sv
// Self-checking bench for cve2_fpu_result_sink: queue-based reference model compared every cycle,
// plus directed literal checks. Honours CVE2_FPU_SINK_BYPASS_EN when defined.
module tb_cve2_fpu_result_sink;

    localparam int DEPTH = 2;
    localparam int TW    = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [4:0]    fflags;
    logic          fflagsWe;
    logic [4:0]    fflagsWdata;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    int total = 0;
    int bad   = 0;

    cve2_fpu_result_sink_if #(.TagWidth(TW)) sinkIf ();

    cve2_fpu_result_sink #(.Depth(DEPTH), .TagWidth(TW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus            (sinkIf.slave),
        .flush_i        (flush),
        .fflags_o       (fflags),
        .fflags_we_i    (fflagsWe),
        .fflags_wdata_i (fflagsWdata),
        .count_o        (count),
        .full_o         (full),
        .empty_o        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   data;
        logic [TW-1:0] tag;
        logic [4:0]    st;
    } entry_t;

    entry_t     mQueue[$];
    logic [4:0] mFlags;
    bit         mAccept;
    bit         mPop;
    logic [4:0] mRetired;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: results retire in order, only when taken at writeback outside a flush.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mQueue.delete();
            mFlags = '0;
        end else begin
            mAccept  = sinkIf.fpu_out_valid && (mQueue.size() < DEPTH) && !flush;
            mPop     = (mQueue.size() > 0) && sinkIf.wb_ready && !flush;
            mRetired = mPop ? mQueue[0].st : 5'b0;
`ifdef CVE2_FPU_SINK_BYPASS_EN
            if (mAccept && mQueue.size() == 0 && sinkIf.wb_ready) begin
                mRetired = sinkIf.fpu_status;
                mAccept  = 1'b0;
            end
`endif
            mFlags = (fflagsWe ? fflagsWdata : mFlags) | mRetired;
            if (flush) begin
                mQueue.delete();
            end else begin
                if (mPop) void'(mQueue.pop_front());
                if (mAccept) mQueue.push_back('{sinkIf.fpu_result, sinkIf.fpu_tag, sinkIf.fpu_status});
            end
        end
    end

    // Compare every output against the model mid-cycle while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            logic          expValid;
            logic [31:0]   expData;
            logic [TW-1:0] expRd;
            expValid = mQueue.size() > 0;
            expData  = expValid ? mQueue[0].data : 32'h0;
            expRd    = expValid ? mQueue[0].tag : '0;
`ifdef CVE2_FPU_SINK_BYPASS_EN
            if (mQueue.size() == 0 && sinkIf.fpu_out_valid && sinkIf.wb_ready && !flush) begin
                expValid = 1'b1;
                expData  = sinkIf.fpu_result;
                expRd    = sinkIf.fpu_tag;
            end
`endif
            checkOutput("cmp_wb_valid", 32'(sinkIf.wb_valid), 32'(expValid));
            checkOutput("cmp_wb_wdata", sinkIf.wb_wdata, expData);
            checkOutput("cmp_wb_rd", 32'(sinkIf.wb_rd), 32'(expRd));
            checkOutput("cmp_count", 32'(count), 32'(mQueue.size()));
            checkOutput("cmp_full", 32'(full), 32'(mQueue.size() == DEPTH));
            checkOutput("cmp_empty", 32'(empty), 32'(mQueue.size() == 0));
            checkOutput("cmp_ready", 32'(sinkIf.fpu_out_ready), 32'(mQueue.size() < DEPTH));
            checkOutput("cmp_fflags", 32'(fflags), 32'(mFlags));
        end
    end

    task automatic setInputs(input bit valid, input logic [31:0] data, input logic [TW-1:0] tag,
                             input logic [4:0] st, input bit wbReady, input bit fl,
                             input bit we, input logic [4:0] wdata);
        sinkIf.fpu_out_valid = valid;
        sinkIf.fpu_result    = data;
        sinkIf.fpu_tag       = tag;
        sinkIf.fpu_status    = st;
        sinkIf.wb_ready      = wbReady;
        flush                = fl;
        fflagsWe             = we;
        fflagsWdata          = wdata;
    endtask

    // One clock of stimulus; valid/flush/CSR write are one-shot, wb_ready is left as driven.
    task automatic applyStimulus(input bit valid, input logic [31:0] data, input logic [TW-1:0] tag,
                                 input logic [4:0] st, input bit wbReady, input bit fl,
                                 input bit we, input logic [4:0] wdata);
        setInputs(valid, data, tag, st, wbReady, fl, we, wdata);
        @(posedge clk);
        #1;
        sinkIf.fpu_out_valid = 1'b0;
        flush                = 1'b0;
        fflagsWe             = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        setInputs(0, 32'h0, '0, 5'b0, 0, 0, 0, 5'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        checkOutput("rst_wb_valid", 32'(sinkIf.wb_valid), 32'd0);
        checkOutput("rst_fflags", 32'(fflags), 32'd0);
        checkOutput("rst_ready", 32'(sinkIf.fpu_out_ready), 32'd1);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] single result with NX");
        applyStimulus(1, 32'h3F800000, 5'd5, 5'b00001, 1, 0, 0, 5'b0);
`ifdef CVE2_FPU_SINK_BYPASS_EN
        checkOutput("nx_bypass_count", 32'(count), 32'd0);
        checkOutput("nx_bypass_fflags", 32'(fflags), 32'h01);
`else
        checkOutput("nx_wb_valid", 32'(sinkIf.wb_valid), 32'd1);
        checkOutput("nx_wb_wdata", sinkIf.wb_wdata, 32'h3F800000);
        checkOutput("nx_wb_rd", 32'(sinkIf.wb_rd), 32'd5);
`endif
        applyStimulus(0, 32'h0, '0, 5'b0, 1, 0, 0, 5'b0);
        checkOutput("nx_fflags", 32'(fflags), 32'h01);
        checkOutput("nx_empty", 32'(empty), 32'd1);

        $display("[TB] fill to full, third result held");
        applyStimulus(1, 32'hA1, 5'd1, 5'b0, 0, 0, 0, 5'b0);
        applyStimulus(1, 32'hA2, 5'd2, 5'b0, 0, 0, 0, 5'b0);
        checkOutput("full_full", 32'(full), 32'd1);
        checkOutput("full_ready", 32'(sinkIf.fpu_out_ready), 32'd0);
        checkOutput("full_head_rd", 32'(sinkIf.wb_rd), 32'd1);
        applyStimulus(1, 32'hA3, 5'd3, 5'b00010, 0, 0, 0, 5'b0);
        checkOutput("full_held_count", 32'(count), 32'd2);
        applyStimulus(1, 32'hA3, 5'd3, 5'b00010, 1, 0, 0, 5'b0);
        checkOutput("drain1_count", 32'(count), 32'd1);
        checkOutput("drain1_rd", 32'(sinkIf.wb_rd), 32'd2);
        applyStimulus(1, 32'hA3, 5'd3, 5'b00010, 1, 0, 0, 5'b0);
        checkOutput("drain2_rd", 32'(sinkIf.wb_rd), 32'd3);
        checkOutput("drain2_wdata", sinkIf.wb_wdata, 32'hA3);
        applyStimulus(0, 32'h0, '0, 5'b0, 1, 0, 0, 5'b0);
        checkOutput("drain3_empty", 32'(empty), 32'd1);
        checkOutput("drain3_fflags", 32'(fflags), 32'h03);

        $display("[TB] flush discards buffered DZ results");
        applyStimulus(1, 32'hD1, 5'd7, 5'b01000, 0, 0, 0, 5'b0);
        applyStimulus(1, 32'hD2, 5'd8, 5'b01000, 0, 0, 0, 5'b0);
        applyStimulus(1, 32'hD3, 5'd9, 5'b01000, 1, 1, 0, 5'b0);
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_wb_valid", 32'(sinkIf.wb_valid), 32'd0);
        checkOutput("flush_fflags", 32'(fflags), 32'h03);
        applyStimulus(1, 32'hD4, 5'd10, 5'b01000, 0, 0, 0, 5'b0);
        applyStimulus(1, 32'hD5, 5'd11, 5'b01000, 1, 1, 0, 5'b0);
        checkOutput("flush2_count", 32'(count), 32'd0);
        setInputs(1, 32'hD6, 5'd12, 5'b01000, 1, 1, 0, 5'b0);
        #1;
        checkOutput("flush_nobypass_valid", 32'(sinkIf.wb_valid), 32'd0);
        applyStimulus(1, 32'hD6, 5'd12, 5'b01000, 1, 1, 0, 5'b0);
        checkOutput("flush3_fflags", 32'(fflags), 32'h03);

        $display("[TB] CSR write concurrent with pop");
        applyStimulus(0, 32'h0, '0, 5'b0, 0, 0, 1, 5'b10000);
        checkOutput("csr_write", 32'(fflags), 32'h10);
        applyStimulus(1, 32'hE1, 5'd4, 5'b00100, 0, 0, 0, 5'b0);
        applyStimulus(0, 32'h0, '0, 5'b0, 1, 0, 1, 5'b00000);
        checkOutput("csr_pop_fflags", 32'(fflags), 32'h04);
        checkOutput("csr_pop_empty", 32'(empty), 32'd1);

        $display("[TB] empty-FIFO latency");
        setInputs(1, 32'h40000000, 5'd3, 5'b0, 1, 0, 0, 5'b0);
        #1;
`ifdef CVE2_FPU_SINK_BYPASS_EN
        checkOutput("lat_same_valid", 32'(sinkIf.wb_valid), 32'd1);
        checkOutput("lat_same_wdata", sinkIf.wb_wdata, 32'h40000000);
`else
        checkOutput("lat_same_valid", 32'(sinkIf.wb_valid), 32'd0);
`endif
        applyStimulus(1, 32'h40000000, 5'd3, 5'b0, 1, 0, 0, 5'b0);
`ifdef CVE2_FPU_SINK_BYPASS_EN
        checkOutput("lat_next_count", 32'(count), 32'd0);
`else
        checkOutput("lat_next_valid", 32'(sinkIf.wb_valid), 32'd1);
        checkOutput("lat_next_wdata", sinkIf.wb_wdata, 32'h40000000);
`endif
        applyStimulus(0, 32'h0, '0, 5'b0, 1, 0, 0, 5'b0);

        $display("[TB] streaming and pointer wrap");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 32'hC0000000 + 32'(i), TW'(i + 13), (i == 3) ? 5'b10000 : 5'b0,
                          1, 0, 0, 5'b0);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i != 5, 32'hB0000000 + 32'(i), TW'(i + 20), (i == 6) ? 5'b00010 : 5'b0,
                          i[0], 0, 0, 5'b0);
        end
        repeat (3) applyStimulus(0, 32'h0, '0, 5'b0, 1, 0, 0, 5'b0);

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1, 32'hF1, 5'd1, 5'b00001, 0, 0, 0, 5'b0);
        applyStimulus(1, 32'hF2, 5'd2, 5'b00001, 0, 0, 0, 5'b0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("arst_count", 32'(count), 32'd0);
        checkOutput("arst_wb_valid", 32'(sinkIf.wb_valid), 32'd0);
        checkOutput("arst_fflags", 32'(fflags), 32'd0);
        checkOutput("arst_ready", 32'(sinkIf.fpu_out_ready), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) applyStimulus(0, 32'h0, '0, 5'b0, 1, 0, 0, 5'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
